// File: rtl/tc_multi_pkg.sv
// Shared constants for the multi-channel bus timer: register map, CTRL fields,
// mode encodings and the per-channel state type.
package tc_multi_pkg;

  // Each channel owns a 16-byte window of four 32-bit registers.
  localparam int CH_WIN = 16;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int STATUS_PEND   = 0;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } ch_state_e;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tc_multi_if.sv
// Bridge-side bus of the timer block: write strobe, byte enables, address,
// data in, combinational read data and the interrupt level.
interface tc_multi_if;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output WE, BE, Addr, Din, input Dout, IRQ);
  modport slave  (input WE, BE, Addr, Din, output Dout, IRQ);
endinterface

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers and the
// IDLE -> LOAD -> CNT -> INT sequencing FSM.
module tc_channel
  import tc_multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  logic             wr_preset,
  input  logic             wr_status,
  input  logic [3:0]       BE,
  input  logic [31:0]      Din,
  output logic [31:0]      ctrl,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pend,
  output logic             irq
);

  ch_state_e        r_state;
  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_pend;

  logic [31:0] w_preset_next;
  logic        w_ctrl_wr;
  logic        w_pend_clr;
  logic        w_auto;

  assign w_preset_next = byte_merge(32'(r_preset), Din, BE);
  // Every CTRL field lives in byte 0, so BE[0] alone gates a CTRL update.
  assign w_ctrl_wr     = wr_ctrl & BE[0];
  assign w_pend_clr    = wr_status & BE[0] & Din[STATUS_PEND];
  assign w_auto        = (r_mode == MODE_AUTO);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the register values from before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_en     <= 1'b0;
      r_mode   <= MODE_ONESHOT;
      r_im     <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en   <= Din[CTRL_EN];
        r_mode <= Din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_im   <= Din[CTRL_IM];
      end
      if (wr_preset) r_preset <= w_preset_next[CNT_W-1:0];
      if (w_pend_clr) r_pend <= 1'b0;

      // NOTE: the FSM assignments come after the bus writes on purpose; when
      // both hit the same register on one edge the later one (a PEND set)
      // takes effect.
      case (r_state)
        ST_IDLE: begin
          if (r_en) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_en) begin
            r_state <= ST_IDLE;
          end else if (r_count == '0) begin
            r_state <= ST_INT;
            r_pend  <= 1'b1;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        ST_INT: begin
          if (w_auto && r_en) begin
            r_state <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
            // A software CTRL write on this edge overrides the one-shot EN clear.
            if (!w_auto && !w_ctrl_wr) r_en <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl   = {28'd0, r_im, r_mode, r_en};
  assign preset = r_preset;
  assign count  = r_count;
  assign pend   = r_pend;
  assign irq    = r_pend & r_im;

endmodule

// File: rtl/tc_multi.sv
// NUM_CH independent down-counting timers sharing one bridge slot: address
// decode, per-channel write strobes, combinational read mux and IRQ OR.
module tc_multi
  import tc_multi_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  tc_multi_if.slave   bus
);

  localparam logic [31:0] SPAN = 32'(CH_WIN * NUM_CH);

  logic [31:0]      w_offset;
  logic             w_in_range;
  logic [1:0]       w_reg;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_irq;
  logic [31:0]      w_ctrl   [NUM_CH];
  logic [CNT_W-1:0] w_preset [NUM_CH];
  logic [CNT_W-1:0] w_count  [NUM_CH];
  logic [31:0]      w_dout;

  // Offset is only meaningful when Addr >= BASE_ADDR; the range check guards it.
  assign w_offset   = bus.Addr - BASE_ADDR;
  assign w_in_range = (bus.Addr >= BASE_ADDR) && (w_offset < SPAN);
  assign w_reg      = bus.Addr[3:2];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_wr;
    assign w_sel[i] = w_in_range && (w_offset[31:4] == 28'(i));
    assign w_wr     = bus.WE & w_sel[i];

    tc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (w_wr && (w_reg == REG_CTRL)),
      .wr_preset (w_wr && (w_reg == REG_PRESET)),
      .wr_status (w_wr && (w_reg == REG_STATUS)),
      .BE        (bus.BE),
      .Din       (bus.Din),
      .ctrl      (w_ctrl[i]),
      .preset    (w_preset[i]),
      .count     (w_count[i]),
      .pend      (w_pend[i]),
      .irq       (w_irq[i])
    );
  end

  // NOTE: w_dout gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel[i]) begin
        case (w_reg)
          REG_CTRL:   w_dout = w_ctrl[i];
          REG_PRESET: w_dout = 32'(w_preset[i]);
          REG_COUNT:  w_dout = 32'(w_count[i]);
          REG_STATUS: w_dout = {31'd0, w_pend[i]};
          default:    w_dout = '0;
        endcase
      end
    end
  end

  assign bus.Dout = w_dout;
  assign bus.IRQ  = |w_irq;

endmodule

// File: tb/tb_tc_multi.sv
// Self-checking bench for tc_multi: register-access vectors, hand-written
// timing sequences and a randomized run against an arithmetic timing model.
module tb_tc_multi;
  import tc_multi_pkg::*;

  localparam int          NCH  = 2;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [3:0]  BE_ALL = 4'hF;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  tc_multi_if bus_if ();

  tc_multi #(.NUM_CH(NCH), .CNT_W(32), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ra(input int ch, input logic [1:0] r);
    return BASE + 32'(ch * 16) + {28'd0, r, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_if.Addr = a;
    bus_if.Din  = d;
    bus_if.BE   = be;
    bus_if.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.WE   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.Addr = a;
    #1;
    d = bus_if.Dout;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic apply_reset();
    bus_if.WE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Random-test variables (static, assigned inside the loop).
  int          r_ch, r_p, r_per;
  logic [1:0]  r_mode;
  logic        r_im, r_auto, r_clr, r_set, pend_m, en_m;
  int          cnt_m, ph;
  logic [31:0] d;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    bus_if.WE   = 1'b0;
    bus_if.BE   = 4'h0;
    bus_if.Addr = 32'h0;
    bus_if.Din  = 32'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ---------------- register-access vectors (all channels idle) --------
    vecs.push_back('{1'b0, ra(0, REG_CTRL),   32'h0,         4'h0,    32'h0});
    vecs.push_back('{1'b0, ra(1, REG_PRESET), 32'h0,         4'h0,    32'h0});
    vecs.push_back('{1'b0, ra(1, REG_STATUS), 32'h0,         4'h0,    32'h0});
    vecs.push_back('{1'b1, ra(0, REG_PRESET), 32'hAABBCCDD,  4'b0011, 32'h0000CCDD});
    vecs.push_back('{1'b1, ra(0, REG_PRESET), 32'h11223344,  4'b1000, 32'h1100CCDD});
    vecs.push_back('{1'b1, ra(0, REG_PRESET), 32'h55667788,  4'b0000, 32'h1100CCDD});
    vecs.push_back('{1'b1, ra(0, REG_COUNT),  32'hFFFFFFFF,  BE_ALL,  32'h0});
    vecs.push_back('{1'b1, ra(0, REG_CTRL),   32'hFFFFFFFE,  BE_ALL,  32'h0000000E});
    vecs.push_back('{1'b1, ra(0, REG_CTRL),   32'h00000000,  4'b0010, 32'h0000000E});
    vecs.push_back('{1'b1, ra(0, REG_STATUS), 32'h00000001,  BE_ALL,  32'h0});
    vecs.push_back('{1'b1, BASE + 32'(16 * NCH), 32'hFFFFFFFF, BE_ALL, 32'h0});
    vecs.push_back('{1'b0, BASE - 32'd4,      32'h0,         4'h0,    32'h0});
    vecs.push_back('{1'b0, ra(1, REG_CTRL),   32'h0,         4'h0,    32'h0});
    vecs.push_back('{1'b1, ra(1, REG_PRESET), 32'h12345678,  BE_ALL,  32'h12345678});
    vecs.push_back('{1'b0, ra(0, REG_PRESET), 32'h0,         4'h0,    32'h1100CCDD});
    vecs.push_back('{1'b1, ra(0, REG_CTRL),   32'h00000000,  BE_ALL,  32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].din, vecs[i].be);
      rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    check("vec_irq_idle", {31'd0, bus_if.IRQ}, 32'h0);

    // ---------------- one-shot ch0, P=5, EN+IM --------------------------
    apply_reset();
    wr(ra(0, REG_PRESET), 32'd5, BE_ALL);
    wr(ra(0, REG_CTRL), 32'h9, BE_ALL);
    for (int n = 1; n <= 10; n++) begin
      tick();
      check($sformatf("oneshot_irq_n%0d", n), {31'd0, bus_if.IRQ}, (n >= 8) ? 32'h1 : 32'h0);
    end
    rd_chk("oneshot_ctrl", ra(0, REG_CTRL), 32'h8);
    rd_chk("oneshot_count", ra(0, REG_COUNT), 32'h0);
    repeat (5) tick();
    rd_chk("oneshot_idle_count", ra(0, REG_COUNT), 32'h0);
    rd_chk("oneshot_idle_stat", ra(0, REG_STATUS), 32'h1);

    // ---------------- auto-reload ch1, P=3 -----------------------------
    apply_reset();
    wr(ra(1, REG_PRESET), 32'd3, BE_ALL);
    wr(ra(1, REG_CTRL), 32'hB, BE_ALL);
    for (int n = 1; n <= 6; n++) begin
      tick();
      rd_chk($sformatf("auto_stat_n%0d", n), ra(1, REG_STATUS), (n >= 6) ? 32'h1 : 32'h0);
    end
    check("auto_irq_n6", {31'd0, bus_if.IRQ}, 32'h1);
    wr(ra(1, REG_STATUS), 32'h1, BE_ALL);                       // edge 7
    rd_chk("auto_w1c_stat", ra(1, REG_STATUS), 32'h0);
    check("auto_w1c_irq", {31'd0, bus_if.IRQ}, 32'h0);
    tick();                                                      // edge 8
    rd_chk("auto_reload_count", ra(1, REG_COUNT), 32'd3);
    repeat (3) tick();                                           // edge 11
    rd_chk("auto_pre_set_stat", ra(1, REG_STATUS), 32'h0);
    wr(ra(1, REG_STATUS), 32'h1, BE_ALL);                       // edge 12: set wins
    rd_chk("auto_set_wins", ra(1, REG_STATUS), 32'h1);
    check("auto_set_wins_irq", {31'd0, bus_if.IRQ}, 32'h1);
    wr(ra(1, REG_STATUS), 32'h1, BE_ALL);                       // edge 13
    rd_chk("auto_clear2", ra(1, REG_STATUS), 32'h0);

    // ---------------- P=0 and bus-write-wins over one-shot EN clear ------
    apply_reset();
    wr(ra(0, REG_CTRL), 32'h9, BE_ALL);                         // P=0 after reset
    tick(); tick();
    check("p0_irq_n2", {31'd0, bus_if.IRQ}, 32'h0);
    tick();
    check("p0_irq_n3", {31'd0, bus_if.IRQ}, 32'h1);
    wr(ra(0, REG_CTRL), 32'h9, BE_ALL);                         // edge 4 = INT cycle
    rd_chk("p0_bus_wins_ctrl", ra(0, REG_CTRL), 32'h9);
    wr(ra(0, REG_STATUS), 32'h1, BE_ALL);                       // edge 5
    rd_chk("p0_cleared", ra(0, REG_STATUS), 32'h0);
    tick();
    rd_chk("p0_n6_stat", ra(0, REG_STATUS), 32'h0);
    tick();
    rd_chk("p0_n7_stat", ra(0, REG_STATUS), 32'h1);
    tick();
    rd_chk("p0_n8_ctrl", ra(0, REG_CTRL), 32'h8);

    // ---------------- mask and isolation ------------------------------
    apply_reset();
    wr(ra(1, REG_PRESET), 32'h77, BE_ALL);
    wr(ra(1, REG_CTRL), 32'h8, BE_ALL);
    wr(ra(0, REG_PRESET), 32'd2, BE_ALL);
    wr(ra(0, REG_CTRL), 32'h1, BE_ALL);
    repeat (5) tick();
    rd_chk("mask_pend", ra(0, REG_STATUS), 32'h1);
    check("mask_irq_low", {31'd0, bus_if.IRQ}, 32'h0);
    wr(ra(0, REG_CTRL), 32'h8, BE_ALL);
    check("mask_irq_high", {31'd0, bus_if.IRQ}, 32'h1);
    rd_chk("iso_ch1_preset", ra(1, REG_PRESET), 32'h77);
    rd_chk("iso_ch1_ctrl", ra(1, REG_CTRL), 32'h8);
    rd_chk("iso_ch1_stat", ra(1, REG_STATUS), 32'h0);
    rd_chk("iso_ch1_count", ra(1, REG_COUNT), 32'h0);

    // ---------------- mid-run EN clear and PRESET write ---------------
    apply_reset();
    wr(ra(0, REG_PRESET), 32'd10, BE_ALL);
    wr(ra(0, REG_CTRL), 32'h1, BE_ALL);
    repeat (4) tick();
    rd_chk("midrun_count_n4", ra(0, REG_COUNT), 32'd8);
    wr(ra(0, REG_CTRL), 32'h0, BE_ALL);                         // edge 5: count 7
    rd_chk("midrun_count_at_clear", ra(0, REG_COUNT), 32'd7);
    repeat (3) tick();
    rd_chk("midrun_count_hold", ra(0, REG_COUNT), 32'd7);
    rd_chk("midrun_ctrl", ra(0, REG_CTRL), 32'h0);
    wr(ra(0, REG_CTRL), 32'h1, BE_ALL);
    repeat (3) tick();
    rd_chk("restart_count_n3", ra(0, REG_COUNT), 32'd9);
    wr(ra(0, REG_PRESET), 32'd2, BE_ALL);                       // edge 4
    rd_chk("preset_during_cnt", ra(0, REG_COUNT), 32'd8);
    rd_chk("preset_readback", ra(0, REG_PRESET), 32'd2);
    repeat (8) tick();                                           // edge 12
    rd_chk("restart_stat_n12", ra(0, REG_STATUS), 32'h0);
    tick();
    rd_chk("restart_stat_n13", ra(0, REG_STATUS), 32'h1);

    // ---------------- async reset mid-count ---------------------------
    apply_reset();
    wr(ra(0, REG_PRESET), 32'd20, BE_ALL);
    wr(ra(0, REG_CTRL), 32'hB, BE_ALL);
    wr(ra(1, REG_PRESET), 32'd5, BE_ALL);
    wr(ra(1, REG_CTRL), 32'h9, BE_ALL);
    repeat (8) tick();
    check("rst_pre_irq", {31'd0, bus_if.IRQ}, 32'h1);
    #1;
    reset = 1'b1;                                                // off the clock edge
    #1;
    check("rst_irq", {31'd0, bus_if.IRQ}, 32'h0);
    rd_chk("rst_ch0_count", ra(0, REG_COUNT), 32'h0);
    rd_chk("rst_ch0_ctrl", ra(0, REG_CTRL), 32'h0);
    rd_chk("rst_ch0_preset", ra(0, REG_PRESET), 32'h0);
    rd_chk("rst_ch1_stat", ra(1, REG_STATUS), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("oor_read", BASE + 32'(16 * NCH), 32'h0);

    // ---------------- randomized run against timing model ---------------
    for (int it = 0; it < 30; it++) begin
      r_ch   = $urandom_range(0, NCH - 1);
      r_p    = $urandom_range(0, 8);
      r_mode = 2'($urandom_range(0, 3));
      r_im   = 1'($urandom_range(0, 1));
      r_per  = r_p + 3;
      r_auto = (r_mode == 2'b01);
      apply_reset();
      wr(ra(r_ch, REG_PRESET), 32'(r_p), BE_ALL);
      wr(ra(r_ch, REG_CTRL), {28'd0, r_im, r_mode, 1'b1}, BE_ALL);
      pend_m = 1'b0;
      for (int n = 1; n <= 2 * r_per + 3; n++) begin
        r_clr = ($urandom_range(0, 5) == 0);
        if (r_clr) wr(ra(r_ch, REG_STATUS), 32'h1, BE_ALL);
        else tick();
        // Timeouts land every P+3 edges; one-shot only produces the first.
        r_set = ((n % r_per) == 0) && (r_auto || n == r_per);
        if (r_set) pend_m = 1'b1;
        else if (r_clr) pend_m = 1'b0;
        en_m = r_auto || (n <= r_per);
        if (n < 2) cnt_m = 0;
        else begin
          ph = (n - 2) % r_per;
          if (!r_auto && (n - 2) > r_p) cnt_m = 0;
          else cnt_m = (ph <= r_p) ? (r_p - ph) : 0;
        end
        rd(ra(r_ch, REG_COUNT), d);
        check($sformatf("rnd%0d_n%0d_count", it, n), d, 32'(cnt_m));
        rd(ra(r_ch, REG_STATUS), d);
        check($sformatf("rnd%0d_n%0d_stat", it, n), d, {31'd0, pend_m});
        rd(ra(r_ch, REG_CTRL), d);
        check($sformatf("rnd%0d_n%0d_ctrl", it, n), d, {28'd0, r_im, r_mode, en_m});
        check($sformatf("rnd%0d_n%0d_irq", it, n), {31'd0, bus_if.IRQ}, {31'd0, pend_m & r_im});
      end
      rd(ra(1 - r_ch, REG_CTRL), d);
      check($sformatf("rnd%0d_other_ctrl", it), d, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
